// File: rtl/btn_debounce_array.sv
// rtl/btn_debounce_array.sv - multi-channel button synchroniser, debouncer, edge/long-press/auto-repeat detector
// Optional feature macro: BTN_DEBOUNCE_REPEAT_EN (builds the repeat counters and btn_rpt; otherwise btn_rpt is 0).
module btn_debounce_array #(
   parameter int              N_CH          = 5,
   parameter int              STABLE_CYCLES = 250000,
   parameter int              LONG_CYCLES   = 100000000,
   parameter int              REPEAT_CYCLES = 20000000,
   parameter logic [N_CH-1:0] INV_MASK      = {N_CH{1'b0}}
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_db,
   output logic [N_CH-1:0] btn_rise,
   output logic [N_CH-1:0] btn_fall,
   output logic [N_CH-1:0] btn_long,
   output logic [N_CH-1:0] btn_rpt
);

   localparam int SW = $clog2(STABLE_CYCLES);
   localparam int HW = $clog2(LONG_CYCLES);
   localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST   = HW'(LONG_CYCLES - 1);
`ifdef BTN_DEBOUNCE_REPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES);
   localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      LONG  = 2'd2
   } state_t;

   genvar i;
   generate
      for (i = 0; i < N_CH; i++) begin : g_ch
         logic          raw;
         logic          sync0;
         logic          sync1;
         logic [SW-1:0] db_cnt;
         logic          db_q;
         logic          rise_q;
         logic          fall_q;
         logic          db_flip;
         logic [HW-1:0] hold_cnt;
         state_t        state;
         state_t        state_nxt;
         logic          long_o;
         logic          rpt_o;

         // Active-low buttons are folded to active-high before synchronising.
         assign raw = btn_in[i] ^ INV_MASK[i];

         // The debounced level changes on this edge: sync1 has differed for the full window.
         assign db_flip = (sync1 != db_q) && (db_cnt == STABLE_LAST);

         // Two-flop synchroniser for the asynchronous pin.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync0 <= 1'b0;
               sync1 <= 1'b0;
            end else begin
               sync0 <= raw;
               sync1 <= sync0;
            end
         end

         // Stability counter; any sample matching the current level restarts the window.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               db_cnt <= '0;
               db_q   <= 1'b0;
               rise_q <= 1'b0;
               fall_q <= 1'b0;
            end else begin
               rise_q <= 1'b0;
               fall_q <= 1'b0;
               if (sync1 == db_q) begin
                  db_cnt <= '0;
               end else if (db_cnt == STABLE_LAST) begin
                  db_cnt <= '0;
                  db_q   <= sync1;
                  rise_q <= sync1;
                  fall_q <= ~sync1;
               end else begin
                  db_cnt <= db_cnt + SW'(1);
               end
            end
         end

         // Press-state register.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state <= IDLE;
            end else begin
               state <= state_nxt;
            end
         end

         // Next state; a release on the long-press edge takes priority over entering LONG.
         always_comb begin
            state_nxt = state;
            case (state)
               IDLE: begin
                  if (db_flip) begin
                     state_nxt = PRESS;
                  end
               end
               PRESS: begin
                  if (db_flip) begin
                     state_nxt = IDLE;
                  end else if (hold_cnt == HOLD_LAST) begin
                     state_nxt = LONG;
                  end
               end
               LONG: begin
                  if (db_flip) begin
                     state_nxt = IDLE;
                  end
               end
               default: state_nxt = IDLE;
            endcase
         end

         // Hold time since the debounced rise; parks at its last value instead of wrapping.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               hold_cnt <= '0;
            end else if (state == IDLE) begin
               hold_cnt <= '0;
            end else if (hold_cnt != HOLD_LAST) begin
               hold_cnt <= hold_cnt + HW'(1);
            end
         end

`ifdef BTN_DEBOUNCE_REPEAT_EN
         logic [RW-1:0] rpt_cnt;

         // Repeat phase: zero on entry to LONG, wraps every REPEAT_CYCLES while held.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rpt_cnt <= '0;
            end else if (state != LONG) begin
               rpt_cnt <= '0;
            end else if (rpt_cnt == RPT_LAST) begin
               rpt_cnt <= '0;
            end else begin
               rpt_cnt <= rpt_cnt + RW'(1);
            end
         end

         // Outputs decoded from state; a repeat pulse fires whenever the phase is zero.
         always_comb begin
            long_o = (state == LONG);
            rpt_o  = (state == LONG) && (rpt_cnt == '0);
         end

         assign btn_rpt[i] = rpt_o;
`else
         // Outputs decoded from state; no auto-repeat in this build.
         always_comb begin
            long_o = (state == LONG);
            rpt_o  = 1'b0;
         end
`endif

         assign btn_db[i]   = db_q;
         assign btn_rise[i] = rise_q;
         assign btn_fall[i] = fall_q;
         assign btn_long[i] = long_o;
      end
   endgenerate

`ifndef BTN_DEBOUNCE_REPEAT_EN
   // REPEAT_CYCLES has no effect in this build; the expression folds to all zeros.
   assign btn_rpt = {N_CH{1'b0}} & {N_CH{REPEAT_CYCLES > 1}};
`endif

endmodule

// File: tb/tb_btn_debounce_array.sv
// tb/tb_btn_debounce_array.sv - scoreboard bench for btn_debounce_array against a history-based reference model
module tb_btn_debounce_array;

   localparam int N    = 2;
   localparam int ST   = 4;
   localparam int LONG = 20;
   localparam int RPT  = 8;
   localparam logic [N-1:0] INV = 2'b10;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] btn_in;
   logic [N-1:0] btn_db, btn_rise, btn_fall, btn_long, btn_rpt;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [N-1:0] db;
      logic [N-1:0] rise;
      logic [N-1:0] fall;
      logic [N-1:0] lng;
      logic [N-1:0] rpt;
   } exp_t;

   exp_t exp_q[$];

   btn_debounce_array #(
      .N_CH(N), .STABLE_CYCLES(ST), .LONG_CYCLES(LONG), .REPEAT_CYCLES(RPT), .INV_MASK(INV)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
      .btn_db(btn_db), .btn_rise(btn_rise), .btn_fall(btn_fall),
      .btn_long(btn_long), .btn_rpt(btn_rpt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
      end
   endtask

   // Reference model: a level flips once the last ST synchronised samples all
   // disagree with it; long/repeat follow from the age of the press in edges.
   logic [N-1:0] m_s0, m_s1, m_db;
   int           m_age[N];
   bit           m_hist[N][$];

   always @(posedge clk) begin
      exp_t e;
      bit   all_ne;
      e = '0;
      if (!rst_n) begin
         m_s0 = '0;
         m_s1 = '0;
         m_db = '0;
         for (int c = 0; c < N; c++) begin
            m_hist[c].delete();
            m_age[c] = 0;
         end
      end else begin
         for (int c = 0; c < N; c++) begin
            m_hist[c].push_back(m_s1[c]);
            if (m_hist[c].size() > ST) void'(m_hist[c].pop_front());
            all_ne = (m_hist[c].size() == ST);
            for (int k = 0; k < m_hist[c].size(); k++)
               if (m_hist[c][k] == m_db[c]) all_ne = 1'b0;
            e.rise[c] = all_ne && !m_db[c];
            e.fall[c] = all_ne && m_db[c];
            if (all_ne) m_db[c] = ~m_db[c];
            if (e.rise[c]) m_age[c] = 0;
            else if (m_db[c]) m_age[c] = m_age[c] + 1;
            e.db[c]  = m_db[c];
            e.lng[c] = m_db[c] && (m_age[c] >= LONG);
`ifdef BTN_DEBOUNCE_REPEAT_EN
            e.rpt[c] = e.lng[c] && (((m_age[c] - LONG) % RPT) == 0);
`endif
         end
         m_s1 = m_s0;
         m_s0 = btn_in ^ INV;
      end
      exp_q.push_back(e);
   end

   // Monitor: compare every presented output cycle against the model's queue.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("sb_db",   32'(btn_db),   32'(e.db));
         chk("sb_rise", 32'(btn_rise), 32'(e.rise));
         chk("sb_fall", 32'(btn_fall), 32'(e.fall));
         chk("sb_long", 32'(btn_long), 32'(e.lng));
         chk("sb_rpt",  32'(btn_rpt),  32'(e.rpt));
      end
   end

   task automatic wait_rise(input int ch, input string name);
      int n;
      n = 0;
      while (!btn_rise[ch] && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!btn_rise[ch]) chk(name, 32'(0), 32'(1));
   endtask

   int  n, k, rpt_seen, long_first;
   bit  seen, seen_long, seen_rpt, seen_fall, prev_long;
   int  hold_left[N];

   initial begin
      btn_in = 2'b10;
      rst_n  = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_outputs", 32'({btn_db, btn_rise, btn_fall, btn_long, btn_rpt}), 32'(0));

      // Clean press and release
      btn_in[0] = 1'b1;
      n = 0;
      while (!btn_db[0] && n < 40) begin @(negedge clk); n++; end
      chk("press_latency", 32'(n), 32'(6));
      chk("press_rise", 32'(btn_rise[0]), 32'(1));
      @(negedge clk);
      chk("rise_one_cycle", 32'(btn_rise[0]), 32'(0));
      repeat (2) @(negedge clk);
      btn_in[0] = 1'b0;
      n = 0;
      while (btn_db[0] && n < 40) begin @(negedge clk); n++; end
      chk("release_latency", 32'(n), 32'(6));
      chk("release_fall", 32'(btn_fall[0]), 32'(1));
      repeat (6) @(negedge clk);

      // Bounce shorter than the window
      seen = 1'b0;
      for (int r = 0; r < 10; r++) begin
         btn_in[0] = 1'b1;
         repeat (3) begin @(negedge clk); seen |= btn_db[0] | btn_rise[0] | btn_fall[0]; end
         btn_in[0] = 1'b0;
         repeat (3) begin @(negedge clk); seen |= btn_db[0] | btn_rise[0] | btn_fall[0]; end
      end
      chk("bounce_quiet", 32'(seen), 32'(0));
      repeat (6) @(negedge clk);

      // Long press with auto-repeat
      btn_in[0] = 1'b1;
      wait_rise(0, "long_rise_timeout");
      rpt_seen = 0;
      long_first = -1;
      for (k = 1; k <= 54; k++) begin
         @(negedge clk);
         if (btn_rpt[0]) rpt_seen++;
         if (btn_long[0] && long_first < 0) long_first = k;
      end
      chk("long_delay", 32'(long_first), 32'(LONG));
`ifdef BTN_DEBOUNCE_REPEAT_EN
      chk("rpt_count", 32'(rpt_seen), 32'(5));
`else
      chk("rpt_count", 32'(rpt_seen), 32'(0));
`endif
      btn_in[0] = 1'b0;
      n = 0;
      prev_long = btn_long[0];
      while (!btn_fall[0] && n < 20) begin
         prev_long = btn_long[0];
         @(negedge clk);
         n++;
         if (btn_rpt[0]) rpt_seen++;
      end
      chk("long_before_fall", 32'(prev_long), 32'(1));
      chk("long_clear_with_fall", 32'({btn_fall[0], btn_long[0]}), 32'(2'b10));
`ifdef BTN_DEBOUNCE_REPEAT_EN
      chk("no_rpt_on_release", 32'(rpt_seen), 32'(5));
`endif
      repeat (6) @(negedge clk);

      // Release racing the long-press edge
      btn_in[0] = 1'b1;
      wait_rise(0, "race_rise_timeout");
      repeat (14) @(negedge clk);
      btn_in[0] = 1'b0;
      seen_long = 1'b0; seen_rpt = 1'b0; seen_fall = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen_long |= btn_long[0];
         seen_rpt  |= btn_rpt[0];
         seen_fall |= btn_fall[0];
      end
      chk("race_no_long", 32'({seen_long, seen_rpt}), 32'(0));
      chk("race_fall", 32'(seen_fall), 32'(1));

      // Inverted channel pressed together with channel 0
      btn_in = 2'b01;
      n = 0;
      while (btn_rise == 2'b00 && n < 40) begin @(negedge clk); n++; end
      chk("dual_rise", 32'(btn_rise), 32'(2'b11));
      repeat (3) @(negedge clk);
      btn_in = 2'b10;
      repeat (10) @(negedge clk);

      // Asynchronous reset in the middle of a press
      btn_in[0] = 1'b1;
      wait_rise(0, "rst_rise_timeout");
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", 32'({btn_db, btn_rise, btn_fall, btn_long, btn_rpt}), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      seen_fall = 1'b0;
      repeat (10) begin @(negedge clk); seen_fall |= btn_fall[0]; end
      chk("no_fall_after_reset", 32'(seen_fall), 32'(0));
      btn_in[0] = 1'b0;
      repeat (10) @(negedge clk);

      // Randomised holds on both channels
      for (int c = 0; c < N; c++) hold_left[c] = 0;
      repeat (3000) begin
         for (int c = 0; c < N; c++) begin
            if (hold_left[c] == 0) begin
               btn_in[c]    = 1'($urandom_range(0, 1));
               hold_left[c] = $urandom_range(1, 40);
            end else begin
               hold_left[c]--;
            end
         end
         @(negedge clk);
      end
      btn_in = 2'b10;
      repeat (20) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
